// File: rtl/snake_engine.sv
// Snake game logic: body register, move timing, wall/self collision, LFSR apple placement, pixel lookup.
// Latency: pixel code registered (1 clk after x_pos/y_pos); moves every TICK_DIV clks; apple search 1+ clks.
// No backpressure: display queries are answered every cycle; a tick landing in apple search is deferred, not dropped. Optional WRAP_EN.
module snake_engine #(
   parameter int          MAX_LEN   = 16,
   parameter int          INIT_LEN  = 3,
   parameter int          TICK_DIV  = 12500000,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] dir_btn,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   output logic [1:0] snake,
   output logic [5:0] apple_x,
   output logic [4:0] apple_y,
   output logic [7:0] score,
   output logic       game_over
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, PLAY, RELOC, DIE} state_t;
   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   state_t        state, state_nxt;
   dir_t          dir, next_dir, btn_dir;
   logic [5:0]    seg_x [MAX_LEN];
   logic [4:0]    seg_y [MAX_LEN];
   logic [LW-1:0] len, hit_lim;
   logic [TW-1:0] tick_cnt;
   logic          tick_pend;
   logic [15:0]   lfsr;

   logic          run, tick, do_move, restart, btn_vld, btn_rev;
   logic [5:0]    nh_x, cx, px;
   logic [4:0]    nh_y, cy, py;
   logic          wall_hit, self_hit, eat, cand_ok, on_snake;
   logic          head_px, body_px, wall_px;
   logic [1:0]    pix_code;
   logic          unused_bits;

   assign unused_bits = ^{x_pos[3:0], y_pos[3:0]};

   assign run       = (state == PLAY) || (state == RELOC);
   assign tick      = run && (tick_cnt == TW'(TICK_DIV - 1));
   assign do_move   = (state == PLAY) && (tick || tick_pend);
   assign restart   = ((state == IDLE) || (state == DIE)) && start;
   assign game_over = (state == DIE);

   // up > down > left > right; opposite directions differ only in bit 0
   always_comb begin
      btn_dir = D_RIGHT;
      if (dir_btn[3])      btn_dir = D_UP;
      else if (dir_btn[2]) btn_dir = D_DOWN;
      else if (dir_btn[1]) btn_dir = D_LEFT;
      btn_vld = |dir_btn;
      btn_rev = (btn_dir[1] == dir[1]) && (btn_dir[0] != dir[0]);
   end

   // the move uses the freshly latched direction; dir follows it on the tick
   always_comb begin
      nh_x = seg_x[0];
      nh_y = seg_y[0];
      case (next_dir)
`ifdef WRAP_EN
         D_UP:    nh_y = (seg_y[0] == 5'd0)  ? 5'd29 : seg_y[0] - 5'd1;
         D_DOWN:  nh_y = (seg_y[0] == 5'd29) ? 5'd0  : seg_y[0] + 5'd1;
         D_LEFT:  nh_x = (seg_x[0] == 6'd0)  ? 6'd39 : seg_x[0] - 6'd1;
         default: nh_x = (seg_x[0] == 6'd39) ? 6'd0  : seg_x[0] + 6'd1;
`else
         D_UP:    nh_y = seg_y[0] - 5'd1;
         D_DOWN:  nh_y = seg_y[0] + 5'd1;
         D_LEFT:  nh_x = seg_x[0] - 6'd1;
         default: nh_x = seg_x[0] + 6'd1;
`endif
      endcase
`ifdef WRAP_EN
      wall_hit = 1'b0;
`else
      wall_hit = (nh_x == 6'd0) || (nh_x == 6'd39) || (nh_y == 5'd0) || (nh_y == 5'd29);
`endif
      eat      = (nh_x == apple_x) && (nh_y == apple_y);
      // the tail vacates its cell unless the snake grows this step
      hit_lim  = len - LW'(1) + LW'(eat);
      self_hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
         if ((LW'(i) < hit_lim) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
            self_hit = 1'b1;
   end

   always_comb begin
      cx       = lfsr[5:0];
      cy       = lfsr[12:8];
      on_snake = 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
         if ((LW'(i) < len) && (seg_x[i] == cx) && (seg_y[i] == cy))
            on_snake = 1'b1;
      cand_ok = (cx >= 6'd1) && (cx <= 6'd38) && (cy >= 5'd1) && (cy <= 5'd28) && !on_snake;
   end

   always_comb begin
      px      = x_pos[9:4];
      py      = y_pos[8:4];
      head_px = (seg_x[0] == px) && (seg_y[0] == py);
      body_px = 1'b0;
      for (int i = 1; i < MAX_LEN; i++)
         if ((LW'(i) < len) && (seg_x[i] == px) && (seg_y[i] == py))
            body_px = 1'b1;
`ifdef WRAP_EN
      wall_px = 1'b0;
`else
      wall_px = (px == 6'd0) || (px == 6'd39) || (py == 5'd0) || (py == 5'd29);
`endif
      pix_code = 2'b00;
      if ((x_pos < 10'd640) && (y_pos < 10'd480)) begin
         if (head_px)      pix_code = 2'b01;
         else if (body_px) pix_code = 2'b10;
         else if (wall_px) pix_code = 2'b11;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = PLAY;
         PLAY:  if (do_move) begin
                   if (wall_hit || self_hit) state_nxt = DIE;
                   else if (eat)             state_nxt = RELOC;
                end
         RELOC: if (cand_ok) state_nxt = PLAY;
         DIE:   if (start) state_nxt = PLAY;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= 6'(20 - i);
            seg_y[i] <= 5'd15;
         end
         len       <= LW'(INIT_LEN);
         dir       <= D_RIGHT;
         next_dir  <= D_RIGHT;
         apple_x   <= 6'd30;
         apple_y   <= 5'd15;
         score     <= 8'd0;
         tick_cnt  <= '0;
         tick_pend <= 1'b0;
         lfsr      <= LFSR_SEED;
         snake     <= 2'b00;
      end else begin
         lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         snake <= pix_code;
         if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
               seg_x[i] <= 6'(20 - i);
               seg_y[i] <= 5'd15;
            end
            len       <= LW'(INIT_LEN);
            dir       <= D_RIGHT;
            next_dir  <= D_RIGHT;
            apple_x   <= 6'd30;
            apple_y   <= 5'd15;
            score     <= 8'd0;
            tick_cnt  <= '0;
            tick_pend <= 1'b0;
         end else begin
            if (run)
               tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if ((state == RELOC) && tick) tick_pend <= 1'b1;
            else if (do_move)             tick_pend <= 1'b0;
            if (run && btn_vld && !btn_rev)
               next_dir <= btn_dir;
            if (do_move) begin
               dir <= next_dir;
               if (!wall_hit && !self_hit) begin
                  for (int i = 1; i < MAX_LEN; i++) begin
                     seg_x[i] <= seg_x[i-1];
                     seg_y[i] <= seg_y[i-1];
                  end
                  seg_x[0] <= nh_x;
                  seg_y[0] <= nh_y;
                  if (eat) begin
                     if (len != LW'(MAX_LEN)) len <= len + LW'(1);
                     if (score != 8'hFF)      score <= score + 8'd1;
                  end
               end
            end
            if ((state == RELOC) && cand_ok) begin
               apple_x <= cx;
               apple_y <= cy;
            end
         end
      end
   end

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine with TICK_DIV=4: reset values, pixel codes, turning, wall death, restart, eating, async reset.
module tb_snake_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] dir_btn;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic [1:0] snake;
   logic [5:0] apple_x;
   logic [4:0] apple_y;
   logic [7:0] score;
   logic       game_over;

   int   checks   = 0;
   int   failures = 0;
   logic found;

   always #5 clk = ~clk;

   snake_engine #(.TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .dir_btn(dir_btn),
      .x_pos(x_pos), .y_pos(y_pos), .snake(snake),
      .apple_x(apple_x), .apple_y(apple_y), .score(score), .game_over(game_over)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // one edge per query; the registered code reflects the state before that edge
   task automatic query(input string tag, input int x, input int y, input logic [1:0] e);
      x_pos = 10'(x);
      y_pos = 10'(y);
      @(posedge clk); #1;
      chk(tag, 32'(snake), 32'(e));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; dir_btn = 4'b0000; x_pos = 10'd0; y_pos = 10'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_snake",   32'(snake),     32'd0);
      chk("rst_apple_x", 32'(apple_x),   32'd30);
      chk("rst_apple_y", 32'(apple_y),   32'd15);
      chk("rst_score",   32'(score),     32'd0);
      chk("rst_over",    32'(game_over), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // IDLE field: head (20,15), body (19,15),(18,15)
      query("q_corner_wall", 0,   0,   2'b11);
      query("q_x_offscreen", 700, 240, 2'b00);
      query("q_y_offscreen", 100, 480, 2'b00);
      query("q_body_seg1",   304, 240, 2'b10);
      query("q_head_init",   320, 240, 2'b01);
      query("q_body_tail",   288, 240, 2'b10);
      query("q_past_tail",   272, 240, 2'b00);
      query("q_right_wall",  624, 240, 2'b11);

      // start edge E0; moves at E4, E8, E12, E16
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      x_pos = 10'd384; y_pos = 10'd240;
      repeat (17) @(posedge clk);
      #1;
      chk("head_after_4_ticks", 32'(snake), 32'd1);
      query("body_after_4_ticks", 368, 240, 2'b10);
      chk("score_no_eat", 32'(score), 32'd0);

      // reversal is ignored: move at E20 still goes right to (25,15)
      dir_btn = 4'b0010;
      x_pos = 10'd400; y_pos = 10'd240;
      repeat (3) @(posedge clk);
      #1;
      chk("reverse_ignored", 32'(snake), 32'd1);

      // up latched at E22, move at E24 to (25,14)
      dir_btn = 4'b1000;
      x_pos = 10'd400; y_pos = 10'd224;
      repeat (4) @(posedge clk);
      #1;
      chk("turn_up", 32'(snake), 32'd1);

      // run right along row 14 into the wall at x=39
      dir_btn = 4'b0001;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(posedge clk); #1;
         if (game_over) found = 1'b1;
      end
      chk("die_on_wall", 32'(found), 32'd1);
      dir_btn = 4'b0000;
      query("frozen_head",  608, 224, 2'b01);
      query("frozen_body",  592, 224, 2'b10);
      query("wall_unshift", 624, 224, 2'b11);
      repeat (6) @(posedge clk);
      #1;
      query("still_frozen", 608, 224, 2'b01);
      chk("over_held", 32'(game_over), 32'd1);

      // restart edge R0; first move at R4
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart_over",  32'(game_over), 32'd0);
      chk("restart_score", 32'(score),     32'd0);
      query("restart_head", 320, 240, 2'b01);
      query("restart_body", 304, 240, 2'b10);

      // tenth move lands on apple (30,15)
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(posedge clk); #1;
         if (score == 8'd1) found = 1'b1;
      end
      chk("eat_score", 32'(found), 32'd1);
      query("grown_tail",   432, 240, 2'b10);
      query("beyond_tail",  416, 240, 2'b00);
      query("head_at_food", 480, 240, 2'b01);

      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         if (!(apple_x == 6'd30 && apple_y == 5'd15)) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk("apple_moved",   32'(found), 32'd1);
      chk("apple_x_range", 32'(apple_x >= 6'd1 && apple_x <= 6'd38), 32'd1);
      chk("apple_y_range", 32'(apple_y >= 5'd1 && apple_y <= 5'd28), 32'd1);
      chk("apple_off_body",
          32'(!(apple_y == 5'd15 && apple_x >= 6'd28 && apple_x <= 6'd30)), 32'd1);

      // fresh game, eat again, then pull reset while in apple search
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      x_pos = 10'd464; y_pos = 10'd240;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(posedge clk); #1;
         if (score == 8'd1) found = 1'b1;
      end
      chk("second_eat",    32'(found), 32'd1);
      chk("pre_rst_snake", 32'(snake), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_snake",   32'(snake),     32'd0);
      chk("mid_rst_score",   32'(score),     32'd0);
      chk("mid_rst_apple_x", 32'(apple_x),   32'd30);
      chk("mid_rst_apple_y", 32'(apple_y),   32'd15);
      chk("mid_rst_over",    32'(game_over), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
Game-logic stage directly upstream of the VGA top level. It owns the snake body, movement timing, collision and apple placement. It answers per-pixel queries: from the display's x_pos/y_pos it returns the 2-bit snake code, and it supplies apple_x/apple_y.
Play field is 40x30 cells of 16x16 px (640x480). The outer ring of cells is wall.

Parameters:
MAX_LEN, 16, maximum snake segments (body register depth)
INIT_LEN, 3, length after reset/restart
TICK_DIV, 12500000, clk cycles per move step (8 Hz at 100 MHz)
LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit apple LFSR

Ports:
clk  input  1  system clock, same clock fed to the VGA top level
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  single-cycle pulse, begin/restart game
dir_btn  input  4  {up,down,left,right}, level, already debounced
x_pos  input  10  current pixel column from VGA stage
y_pos  input  10  current pixel row from VGA stage
snake  output  2  pixel code: 00 empty, 01 head, 10 body, 11 wall
apple_x  output  6  apple cell column, 1..38
apple_y  output  5  apple cell row, 1..28
score  output  8  apples eaten, saturates at 255
game_over  output  1  high while in DIE

Behaviour:
- Reset (rst=0, async): state IDLE.
  - seg[0]=(20,15), seg[1]=(19,15), seg[2]=(18,15); len=INIT_LEN; dir=RIGHT.
  - apple=(30,15), score=0, game_over=0, snake=00, tick counter=0, LFSR=LFSR_SEED.
- The LFSR is 16-bit, taps 16,14,13,11. It advances every clk in every state.
- States:
  - IDLE: frozen. start -> PLAY, tick counter cleared.
  - PLAY: tick counter counts 0..TICK_DIV-1 and wraps; the tick fires on the wrap cycle.
  - RELOC: apple search; the tick counter keeps running.
  - DIE: frozen, game_over=1. start -> reinitialise to reset values (LFSR excepted) -> PLAY.
- Direction:
  - dir_btn is sampled every cycle, priority up>down>left>right.
  - The result is latched into next_dir unless it is the reverse of the current dir.
  - dir <= next_dir on the tick.
- Move, on tick in PLAY: nh = seg[0] + step(dir).
  - Wall hit (nh.x==0, nh.x==39, nh.y==0 or nh.y==29) -> DIE, no shift.
  - Self hit: nh equals seg[0..len-2] -> DIE. When eating, the comparison also includes seg[len-1].
  - Otherwise: seg[i] <= seg[i-1] for i>=1, seg[0] <= nh.
  - Eat (nh==apple): len+1, saturating at MAX_LEN. score+1, saturating at 255. Then -> RELOC.
- RELOC:
  - Candidate cx=lfsr[5:0], cy=lfsr[12:8].
  - Accept when 1<=cx<=38, 1<=cy<=28 and the cell is not on any active segment. On accept, apple updates in that cycle -> PLAY.
  - Otherwise retry next cycle.
  - A tick that lands in RELOC is latched and executed on the first PLAY cycle. It is never dropped and never doubled.
- Pixel query: cell = (x_pos[9:4], y_pos[8:4]). snake is registered, 1 clk latency.
  - x_pos>=640 or y_pos>=480 -> 00.
  - Precedence: head (seg[0]) 01 > body (seg[1..len-1]) 10 > wall ring 11 > 00.
  - Only segments with index < len are active.
- start during PLAY or RELOC is ignored.
- rst mid-move or mid-RELOC returns immediately to the reset values.

Optional Feature:
WRAP_EN:
- Defined:
  - The wall ring is neither drawn nor lethal. The snake code for those cells is 00, or head/body if occupied.
  - The head wraps across the ring: x 0<->39, y 0<->29.
  - Only a self hit causes DIE.
  - Apple placement is unchanged (1..38, 1..28).
- Undefined: wall behaviour as described above.

Test Plan:
- Reset then start, no buttons, TICK_DIV=4 -> after 4 ticks seg[0]=(24,15), len=3, score=0. A pixel query at (384,240) returns 01 one clk later.
- Apple forced to (21,15), one tick -> len=4, score=1. Within RELOC, apple moves to a valid non-snake cell with x in 1..38 and y in 1..28.
- From start press left (reversal of RIGHT) -> ignored, head still moves right. Press up -> next tick head=(20,14).
- Drive right until x reaches 38, then one more tick -> game_over=1 and the snake is frozen. start -> reinit to (20,15) and score=0. With WRAP_EN the head goes to (39,y), then (0,y), with no DIE.
- Queries: x_pos=0,y_pos=0 -> 11; x_pos=700 -> 00; x_pos=304,y_pos=240 -> 10 (seg[1]=(19,15)).
- Assert rst low during RELOC -> all outputs return to reset values on the same edge, apple=(30,15).
